// File: rtl/ucdp_clk_gate_ctrl_pkg.sv
// Shared types and limits for the clock-gate controller.
package ucdp_clk_gate_ctrl_pkg;

   typedef enum logic [1:0] {StOff, StWake, StOn, StHold} state_e;

   localparam int unsigned NumReqMin  = 1;
   localparam int unsigned NumReqMax  = 16;
   localparam int unsigned WakeCycMin = 1;
   localparam int unsigned WakeCycMax = 15;
   localparam int unsigned IdleCycMin = 0;
   localparam int unsigned IdleCycMax = 255;

   function automatic int unsigned cnt_width(input int unsigned wake_cyc,
                                             input int unsigned idle_cyc);
      int unsigned m;
      m = (wake_cyc > idle_cyc) ? wake_cyc : idle_cyc;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/ucdp_clk_gate_ctrl_gate.sv
// Glitch-free clock gate: enable is retimed on the falling edge so it only
// changes while clk_i is low.
module ucdp_clk_gate (
   input  logic clk_i,
   input  logic en_i,
   output logic clk_o
);

   logic en_lo;

   always_ff @(negedge clk_i) begin
      en_lo <= en_i;
   end

   assign clk_o = clk_i & en_lo;

endmodule

// File: rtl/ucdp_clk_gate_ctrl.sv
// Request-driven clock-gate controller with wake latency and idle hysteresis.
module ucdp_clk_gate_ctrl
   import ucdp_clk_gate_ctrl_pkg::*;
#(
   parameter int unsigned NUM_REQ  = 2,
   parameter int unsigned WAKE_CYC = 2,
   parameter int unsigned IDLE_CYC = 3
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NUM_REQ-1:0] req_i,
   input  logic               force_on_i,
   output logic [NUM_REQ-1:0] ack_o,
   output logic               gclk_o,
   output logic               active_o
);

   localparam int unsigned CntW = cnt_width(WAKE_CYC, IDLE_CYC);

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            en_q;
   logic            any;

   assign any = (|req_i) | force_on_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StOff;
         cnt_q   <= '0;
         en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         en_q    <= (state_d != StOff);
      end
   end

   // Counter is loaded only on entry to WAKE/HOLD and saturates at zero.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StOff: begin
            if (any) begin
               state_d = StWake;
               cnt_d   = CntW'(WAKE_CYC - 1);
            end
         end
         StWake: begin
            if (cnt_q == '0) state_d = StOn;
            else             cnt_d   = cnt_q - CntW'(1);
         end
         StOn: begin
            if (!any) begin
               if (IDLE_CYC == 0) begin
                  state_d = StOff;
               end else begin
                  state_d = StHold;
                  cnt_d   = CntW'(IDLE_CYC - 1);
               end
            end
         end
         StHold: begin
            if (any)              state_d = StOn;
            else if (cnt_q == '0) state_d = StOff;
            else                  cnt_d   = cnt_q - CntW'(1);
         end
         default: state_d = StOff;
      endcase
   end

   always_comb begin
      ack_o    = req_i & {NUM_REQ{state_q == StOn}};
      active_o = en_q;
   end

   ucdp_clk_gate u_clk_gate (
      .clk_i (clk_i),
      .en_i  (en_q),
      .clk_o (gclk_o)
   );

endmodule

// File: tb/tb_ucdp_clk_gate_ctrl.sv
// Scoreboard bench for ucdp_clk_gate_ctrl with NUM_REQ=2, WAKE_CYC=2, IDLE_CYC=3.
module tb_ucdp_clk_gate_ctrl;
   import ucdp_clk_gate_ctrl_pkg::*;

   typedef struct {
      state_e     st;
      logic       act;
      logic [1:0] ack;
      logic       gclk;
      bit         chk_g;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] req = 2'b00;
   logic       frc = 1'b0;
   logic [1:0] ack;
   logic       gclk;
   logic       active;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   ucdp_clk_gate_ctrl #(
      .NUM_REQ  (2),
      .WAKE_CYC (2),
      .IDLE_CYC (3)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .req_i      (req),
      .force_on_i (frc),
      .ack_o      (ack),
      .gclk_o     (gclk),
      .active_o   (active)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // Drive one cycle's inputs mid-cycle; expectation is for just after the next rising edge.
   task automatic cyc(input logic [1:0] r, input logic f, input logic rs, input state_e s,
                      input logic a, input logic [1:0] k, input logic g, input bit cg = 1'b1);
      exp_t e;
      @(negedge clk);
      req = r;
      frc = f;
      rst = rs;
      e.st = s; e.act = a; e.ack = k; e.gclk = g; e.chk_g = cg;
      sb.push_back(e);
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check_eq("state", 32'(dut.state_q), 32'(e.st));
         check_eq("active_o", 32'(active), 32'(e.act));
         check_eq("ack_o", 32'(ack), 32'(e.ack));
         if (e.chk_g) check_eq("gclk_o", 32'(gclk), 32'(e.gclk));
      end
   end

   initial begin
      // Reset
      cyc(2'b00, 0, 1, StOff, 0, 2'b00, 0, 1'b0);
      cyc(2'b00, 0, 1, StOff, 0, 2'b00, 0);
      cyc(2'b00, 0, 0, StOff, 0, 2'b00, 0);

      // Wake on req 01, then drop and ride out hysteresis
      cyc(2'b01, 0, 0, StWake, 1, 2'b00, 0);
      cyc(2'b01, 0, 0, StWake, 1, 2'b00, 1);
      cyc(2'b01, 0, 0, StOn,   1, 2'b01, 1);
      cyc(2'b01, 0, 0, StOn,   1, 2'b01, 1);
      cyc(2'b00, 0, 0, StHold, 1, 2'b00, 1);
      cyc(2'b00, 0, 0, StHold, 1, 2'b00, 1);
      cyc(2'b00, 0, 0, StHold, 1, 2'b00, 1);
      cyc(2'b00, 0, 0, StOff,  0, 2'b00, 1);
      cyc(2'b00, 0, 0, StOff,  0, 2'b00, 0);
      cyc(2'b00, 0, 0, StOff,  0, 2'b00, 0);

      // New request in HOLD returns straight to ON
      cyc(2'b01, 0, 0, StWake, 1, 2'b00, 0);
      cyc(2'b01, 0, 0, StWake, 1, 2'b00, 1);
      cyc(2'b01, 0, 0, StOn,   1, 2'b01, 1);
      cyc(2'b00, 0, 0, StHold, 1, 2'b00, 1);
      cyc(2'b00, 0, 0, StHold, 1, 2'b00, 1);
      cyc(2'b10, 0, 0, StOn,   1, 2'b10, 1);
      cyc(2'b10, 0, 0, StOn,   1, 2'b10, 1);
      cyc(2'b00, 0, 0, StHold, 1, 2'b00, 1);
      cyc(2'b00, 0, 0, StHold, 1, 2'b00, 1);
      cyc(2'b00, 0, 0, StHold, 1, 2'b00, 1);
      cyc(2'b00, 0, 0, StOff,  0, 2'b00, 1);
      cyc(2'b00, 0, 0, StOff,  0, 2'b00, 0);

      // One-cycle pulse of 11: full wake, one ON cycle, full hold
      cyc(2'b11, 0, 0, StWake, 1, 2'b00, 0);
      cyc(2'b00, 0, 0, StWake, 1, 2'b00, 1);
      cyc(2'b00, 0, 0, StOn,   1, 2'b00, 1);
      cyc(2'b00, 0, 0, StHold, 1, 2'b00, 1);
      cyc(2'b00, 0, 0, StHold, 1, 2'b00, 1);
      cyc(2'b00, 0, 0, StHold, 1, 2'b00, 1);
      cyc(2'b00, 0, 0, StOff,  0, 2'b00, 1);
      cyc(2'b00, 0, 0, StOff,  0, 2'b00, 0);

      // Force-on holds ON; ack still follows req
      cyc(2'b00, 1, 0, StWake, 1, 2'b00, 0);
      cyc(2'b00, 1, 0, StWake, 1, 2'b00, 1);
      for (int i = 0; i < 5; i++) cyc(2'b00, 1, 0, StOn, 1, 2'b00, 1);
      cyc(2'b01, 1, 0, StOn,   1, 2'b01, 1);
      cyc(2'b00, 1, 0, StOn,   1, 2'b00, 1);
      cyc(2'b00, 0, 0, StHold, 1, 2'b00, 1);
      cyc(2'b00, 0, 0, StHold, 1, 2'b00, 1);
      cyc(2'b00, 0, 0, StHold, 1, 2'b00, 1);
      cyc(2'b00, 0, 0, StOff,  0, 2'b00, 1);
      cyc(2'b00, 0, 0, StOff,  0, 2'b00, 0);

      // Reset while ON, request held: re-wake after release
      cyc(2'b01, 0, 0, StWake, 1, 2'b00, 0);
      cyc(2'b01, 0, 0, StWake, 1, 2'b00, 1);
      cyc(2'b01, 0, 0, StOn,   1, 2'b01, 1);
      cyc(2'b01, 0, 1, StOff,  0, 2'b00, 1);
      cyc(2'b01, 0, 0, StWake, 1, 2'b00, 0);
      cyc(2'b01, 0, 0, StWake, 1, 2'b00, 1);
      cyc(2'b01, 0, 0, StOn,   1, 2'b01, 1);
      cyc(2'b00, 0, 0, StHold, 1, 2'b00, 1);
      cyc(2'b00, 0, 0, StHold, 1, 2'b00, 1);
      cyc(2'b00, 0, 0, StHold, 1, 2'b00, 1);
      cyc(2'b00, 0, 0, StOff,  0, 2'b00, 1);
      cyc(2'b00, 0, 0, StOff,  0, 2'b00, 0);

      begin
         int budget = 20;
         while (sb.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
         end
         @(negedge clk);
         check_eq("scoreboard_drained", 32'(sb.size()), 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
